mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_D_STREAK, default 4: max consecutive data grants while a fetch is pending.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port nreset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_req  input  1  fetch read request; held high until i_ack.
REQ-005 SHALL have port i_addr  input  32  fetch address.
REQ-006 SHALL have port i_ack  output  1  one-cycle pulse: fetch complete, rdata valid.
REQ-007 SHALL have port d_req  input  1  data request; held high until d_ack.
REQ-008 SHALL have port d_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port d_addr  input  32  data address.
REQ-010 SHALL have port d_wdata  input  32  store data.
REQ-011 SHALL have port d_wstrb  input  4  byte write strobes.
REQ-012 SHALL have port d_ack  output  1  one-cycle pulse: data access complete.
REQ-013 SHALL have port rdata  output  32  registered read data, valid with i_ack or d_ack on reads.
REQ-014 SHALL have ports awvalid out 1, awready in 1, awaddr out 32: AXI-lite write address channel.
REQ-015 SHALL have ports wvalid out 1, wready in 1, wdata out 32, wstrb out 4: AXI-lite write data channel.
REQ-016 SHALL have ports bvalid in 1, bready out 1: AXI-lite write response channel; bresp ignored.
REQ-017 SHALL have ports arvalid out 1, arready in 1, araddr out 32: AXI-lite read address channel.
REQ-018 SHALL have ports rvalid in 1, rready out 1, rdata_m in 32: AXI-lite read data channel; rresp ignored.
REQ-019 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, ACK; one transaction outstanding at a time.
REQ-021 SHALL arbitrate only in IDLE: grant if any req high; latch owner, addr, we, wdata, wstrb into registers at grant; requester inputs ignored afterwards.
REQ-022 SHALL give data priority over fetch, except fetch wins when both request and streak counter == MAX_D_STREAK.
REQ-023 SHALL increment streak counter (saturating at MAX_D_STREAK) on a data grant with i_req high; clear it on any fetch grant or a data grant with i_req low.
REQ-024 SHALL go IDLE -> RD_ADDR on fetch grant or data grant with d_we=0; IDLE -> WR on data grant with d_we=1.
REQ-025 RD_ADDR SHALL drive arvalid=1, araddr=latched addr, stable until arready; on arvalid&arready -> RD_DATA.
REQ-026 RD_DATA SHALL drive rready=1; on rvalid capture rdata_m into rdata -> ACK.
REQ-027 WR SHALL assert awvalid and wvalid together on entry; each drops independently after its own handshake; awaddr/wdata/wstrb stable while valid; when both handshakes done (same or different cycles) -> WR_RESP.
REQ-028 WR_RESP SHALL drive bready=1; on bvalid -> ACK; rdata unchanged on writes.
REQ-029 ACK SHALL pulse i_ack or d_ack (owner only) for exactly one cycle, then -> IDLE; no arbitration in ACK.
REQ-030 Requester SHALL drop req on the edge that samples its ack; a req still high in IDLE is a new request.
REQ-031 Minimum latency with zero-wait slave SHALL be 3 cycles from grant cycle to ack cycle, read or write.
REQ-032 awvalid, wvalid, arvalid, rready, bready SHALL be registered outputs, low outside their states.

Reset
REQ-033 nreset low SHALL immediately force state IDLE, streak 0, rdata 0, all valid/ready/ack/busy outputs 0, abandoning any outstanding transaction with no ack.
REQ-034 After nreset deasserts, first grant SHALL occur in the first cycle a req is sampled high.

Verification
- Fetch alone, i_addr=0x10, zero-wait slave, rdata_m=0xDEADBEEF -> arvalid/araddr=0x10 cycle 1, rready cycle 2, i_ack=1 and rdata=0xDEADBEEF cycle 3.
- i_req and d_req rise same cycle, d_we=0 -> data served first (d_ack), fetch granted in next IDLE.
- i_req and d_req held high continuously, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Write d_addr=0x20, d_wdata=0xA5A5A5A5, d_wstrb=0x3, awready delayed 2 cycles, wready immediate -> wvalid 1 cycle, awvalid 3 cycles, values stable, d_ack one cycle after bvalid.
- nreset low during RD_DATA -> all outputs 0 asynchronously, no i_ack; after release a fresh d_req write completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: AXI-lite master/slave bundle for the memory arbiter.
// The write response and read response codes are not carried; they are ignored.
interface mem_arbiter_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata_m;
    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata_m
    );
    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, arready, rvalid, rdata_m
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one AXI-lite master between a fetch port and a data port,
// one transaction at a time, data first but never starving fetch beyond MAX_D_STREAK.
module mem_arbiter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_wstrb,
    output logic          d_ack,
    output logic [31:0]   rdata,
    output logic          busy,
    mem_arbiter_if.master axi
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, ACK} state_t;
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);
    state_t        state;
    logic [SW-1:0] streak;
    logic          owner_d;
    logic [31:0]   addr;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          arvalid, rready, awvalid, wvalid, bready;
    logic          pick_i, aw_done, w_done;
    assign pick_i  = i_req && (!d_req || streak == SMAX);
    assign aw_done = !awvalid || axi.awready;
    assign w_done  = !wvalid || axi.wready;
    assign busy    = state != IDLE;
    assign axi.arvalid = arvalid;
    assign axi.araddr  = addr;
    assign axi.rready  = rready;
    assign axi.awvalid = awvalid;
    assign axi.awaddr  = addr;
    assign axi.wvalid  = wvalid;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.bready  = bready;
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            streak  <= '0;
            rdata   <= '0;
            owner_d <= 1'b0;
            addr    <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_req || d_req) begin
                    owner_d <= !pick_i;
                    addr    <= pick_i ? i_addr : d_addr;
                    wdata_q <= d_wdata;
                    wstrb_q <= d_wstrb;
                    // a data win over a pending fetch implies streak < SMAX, so this saturates
                    streak  <= (!pick_i && i_req) ? streak + SW'(1) : '0;
                    if (!pick_i && d_we) begin
                        state   <= WR;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                    end else begin
                        state   <= RD_ADDR;
                        arvalid <= 1'b1;
                    end
                end
                RD_ADDR: if (axi.arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    state   <= RD_DATA;
                end
                RD_DATA: if (axi.rvalid) begin
                    rready <= 1'b0;
                    rdata  <= axi.rdata_m;
                    i_ack  <= !owner_d;
                    d_ack  <= owner_d;
                    state  <= ACK;
                end
                WR: begin
                    if (axi.awready) awvalid <= 1'b0;
                    if (axi.wready) wvalid <= 1'b0;
                    if (aw_done && w_done) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: if (axi.bvalid) begin
                    bready <= 1'b0;
                    d_ack  <= 1'b1;
                    state  <= ACK;
                end
                ACK: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: cycle-exact vector table, hand-built corner sequences and a
// randomized run against a transaction-level arbitration model with a behavioural AXI-lite slave.
module tb_mem_arbiter;
    localparam int MAX = 4;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;
    logic        clk, nreset;
    logic        i_req, i_ack, d_req, d_we, d_ack, busy;
    logic [31:0] i_addr, d_addr, d_wdata, rdata;
    logic [3:0]  d_wstrb;
    int          total, bad;
    mem_arbiter_if axi();
    mem_arbiter #(.MAX_D_STREAK(MAX)) dut (
        .clk(clk), .nreset(nreset), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ack(d_ack), .rdata(rdata), .busy(busy), .axi(axi)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'h5A5A_C3C3) + 32'h0101_0101;
    endfunction
    function automatic logic [7:0] outs();
        return {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, i_ack, d_ack, busy};
    endfunction
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask
    // Behavioural slave: programmable waits, decisions at negedge, handshakes at the next posedge.
    int          ar_wait, r_wait, aw_wait, w_wait, b_wait;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit          ar_fire, r_fire, aw_fire, w_fire, b_fire, r_pend, b_pend, aw_got, w_got;
    logic [31:0] r_addr, last_ar, last_aw, last_w;
    logic [3:0]  last_ws;
    always @(negedge clk) begin
        if (!nreset) begin
            axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
            axi.rvalid = 1'b0; axi.bvalid = 1'b0; axi.rdata_m = '0;
            {ar_fire, r_fire, aw_fire, w_fire, b_fire, r_pend, b_pend, aw_got, w_got} = '0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end else begin
            if (r_fire) axi.rvalid = 1'b0;
            if (b_fire) axi.bvalid = 1'b0;
            if (ar_fire) begin r_pend = 1; r_cnt = 0; r_addr = last_ar; end
            aw_got |= aw_fire;
            w_got |= w_fire;
            if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
            axi.arready = axi.arvalid && ar_cnt >= ar_wait;
            ar_cnt = axi.arvalid ? ar_cnt + 1 : 0;
            axi.awready = axi.awvalid && aw_cnt >= aw_wait;
            aw_cnt = axi.awvalid ? aw_cnt + 1 : 0;
            axi.wready = axi.wvalid && w_cnt >= w_wait;
            w_cnt = axi.wvalid ? w_cnt + 1 : 0;
            if (r_pend) begin
                if (r_cnt >= r_wait) begin axi.rvalid = 1'b1; axi.rdata_m = slave_data(r_addr); r_pend = 0; end
                else r_cnt++;
            end
            if (b_pend) begin
                if (b_cnt >= b_wait) begin axi.bvalid = 1'b1; b_pend = 0; end
                else b_cnt++;
            end
            ar_fire = axi.arvalid && axi.arready;
            if (ar_fire) last_ar = axi.araddr;
            r_fire = axi.rvalid && axi.rready;
            aw_fire = axi.awvalid && axi.awready;
            if (aw_fire) last_aw = axi.awaddr;
            w_fire = axi.wvalid && axi.wready;
            if (w_fire) begin last_w = axi.wdata; last_ws = axi.wstrb; end
            b_fire = axi.bvalid && axi.bready;
        end
    end
    task automatic wait_ack(output bit gi, output bit gd, output bit ok);
        gi = 0; gd = 0; ok = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk); #1;
            if (i_ack || d_ack) begin gi = i_ack; gd = d_ack; ok = 1; return; end
        end
    endtask
    typedef struct {
        logic i, d, we;
        logic [31:0] da;
        logic [7:0] exp;
        logic crd;
        logic [31:0] rd;
        logic cbus;
        logic [31:0] bus;
    } vec_t;
    vec_t vq[$];
    task automatic add(input logic i, d, we, input logic [31:0] da, input logic [7:0] e,
                       input logic crd, input logic [31:0] rd, input logic cb, input logic [31:0] bus);
        vq.push_back('{i, d, we, da, e, crd, rd, cb, bus});
    endtask
    initial begin
        bit gi, gd, ok, pi, pd, exp_d, got;
        int awc, wc, bcyc, acyc, unstable, acks, m_streak;
        logic [31:0] m_rdata;
        logic [9:0] order;
        total = 0; bad = 0;
        nreset = 1'b0; i_req = 0; d_req = 0; d_we = 0;
        i_addr = 32'h10; d_addr = 32'h40; d_wdata = 32'hA5A5A5A5; d_wstrb = 4'h3;
        ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'(outs()), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        nreset = 1'b1;
        // single fetch; both at once (data first); zero-wait write
        add(T, F, F, 32'h40, 8'h81, F, 0, T, 32'h10);
        add(T, F, F, 32'h40, 8'h41, F, 0, F, 0);
        add(T, F, F, 32'h40, 8'h05, T, 32'hDEADBEEF, F, 0);
        add(F, F, F, 32'h40, 8'h00, F, 0, F, 0);
        add(T, T, F, 32'h40, 8'h81, F, 0, T, 32'h40);
        add(T, T, F, 32'h40, 8'h41, F, 0, F, 0);
        add(T, T, F, 32'h40, 8'h03, T, slave_data(32'h40), F, 0);
        add(T, F, F, 32'h40, 8'h00, F, 0, F, 0);
        add(T, F, F, 32'h40, 8'h81, F, 0, T, 32'h10);
        add(T, F, F, 32'h40, 8'h41, F, 0, F, 0);
        add(T, F, F, 32'h40, 8'h05, T, 32'hDEADBEEF, F, 0);
        add(F, F, F, 32'h40, 8'h00, F, 0, F, 0);
        add(F, T, T, 32'h20, 8'h31, F, 0, T, 32'h20);
        add(F, T, T, 32'h20, 8'h09, F, 0, F, 0);
        add(F, T, T, 32'h20, 8'h03, T, 32'hDEADBEEF, F, 0);
        add(F, F, T, 32'h20, 8'h00, F, 0, F, 0);
        foreach (vq[k]) begin
            @(negedge clk);
            i_req = vq[k].i; d_req = vq[k].d; d_we = vq[k].we; d_addr = vq[k].da;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_outs", k), 32'(outs()), 32'(vq[k].exp));
            if (vq[k].crd) chk($sformatf("vec%0d_rdata", k), rdata, vq[k].rd);
            if (vq[k].cbus) chk($sformatf("vec%0d_addr", k), axi.arvalid ? axi.araddr : axi.awaddr, vq[k].bus);
        end
        chk("wr_values", {last_aw[7:0], last_w[23:0]}, {8'h20, 24'hA5A5A5});
        chk("wr_strb", 32'(last_ws), 32'h3);
        // both held: four data grants then one fetch, repeating
        order = 10'b1111011110;
        @(negedge clk);
        d_we = 0; d_addr = 32'h40; i_req = 1; d_req = 1;
        for (int k = 0; k < 10; k++) begin
            wait_ack(gi, gd, ok);
            if (!ok) begin chk("streak_timeout", 0, 1); break; end
            chk($sformatf("streak_grant%0d", k), 32'(gd), 32'(order[9-k]));
        end
        i_req = 0; d_req = 0;
        // write with awready held off two cycles
        aw_wait = 2;
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hA5A5A5A5; d_wstrb = 4'h3;
        awc = 0; wc = 0; bcyc = -10; acyc = -1; unstable = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); #1;
            if (axi.awvalid) begin awc++; if (axi.awaddr !== 32'h20) unstable++; end
            if (axi.wvalid) begin wc++; if (axi.wdata !== 32'hA5A5A5A5 || axi.wstrb !== 4'h3) unstable++; end
            if (axi.bvalid && axi.bready) bcyc = c;
            if (d_ack) begin acyc = c; d_req = 0; break; end
        end
        d_req = 0;
        chk("dly_awvalid_cycles", 32'(awc), 3);
        chk("dly_wvalid_cycles", 32'(wc), 1);
        chk("dly_values_stable", 32'(unstable), 0);
        chk("dly_ack_after_bvalid", 32'(acyc), 32'(bcyc + 1));
        aw_wait = 0;
        // reset while waiting for read data
        r_wait = 6;
        @(negedge clk);
        i_addr = 32'h30; i_req = 1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (axi.rready) begin got = 1; break; end
        end
        chk("rst_reach_rd_data", 32'(got), 1);
        #1 nreset = 1'b0; i_req = 0;
        #1;
        chk("rst_async_outs", 32'(outs()), 0);
        chk("rst_async_rdata", rdata, 0);
        acks = 0;
        repeat (3) begin @(negedge clk); #1; if (outs() != 0) acks++; end
        chk("rst_hold_quiet", 32'(acks), 0);
        r_wait = 0;
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h1234_5678; d_wstrb = 4'hC;
        @(posedge clk); #1;
        chk("post_rst_first_grant", 32'(outs()), 32'h31);
        wait_ack(gi, gd, ok);
        d_req = 0;
        chk("post_rst_ack", {30'h0, gi, gd}, {30'h0, 1'b0, ok});
        chk("post_rst_awaddr", last_aw, 32'h80);
        chk("post_rst_wdata", last_w, 32'h1234_5678);
        chk("post_rst_rdata", rdata, 0);
        // randomized traffic against a transaction-level arbitration model
        m_streak = 0; m_rdata = 0; pi = 0; pd = 0;
        for (int n = 0; n < 80; n++) begin
            if (!pi && ($urandom_range(1) == 1 || !pd)) begin
                pi = 1; i_addr = $urandom; i_req = 1;
            end
            if (!pd && ($urandom_range(1) == 1 || !pi)) begin
                pd = 1; d_we = 1'($urandom_range(1)); d_addr = $urandom; d_wdata = $urandom;
                d_wstrb = 4'($urandom_range(15)); d_req = 1;
            end
            exp_d = pd && !(pi && m_streak == MAX);
            wait_ack(gi, gd, ok);
            if (!ok) begin chk("rnd_timeout", 0, 1); break; end
            chk($sformatf("rnd%0d_owner", n), {30'h0, gi, gd}, {30'h0, !exp_d, exp_d});
            if (gd) begin
                if (d_we) begin
                    chk($sformatf("rnd%0d_awaddr", n), last_aw, d_addr);
                    chk($sformatf("rnd%0d_wdata", n), last_w, d_wdata);
                    chk($sformatf("rnd%0d_wstrb", n), 32'(last_ws), 32'(d_wstrb));
                end else begin
                    chk($sformatf("rnd%0d_daraddr", n), last_ar, d_addr);
                    m_rdata = slave_data(d_addr);
                end
                m_streak = pi ? (m_streak < MAX ? m_streak + 1 : MAX) : 0;
                pd = 0; d_req = 0;
            end else begin
                chk($sformatf("rnd%0d_iaraddr", n), last_ar, i_addr);
                m_rdata = slave_data(i_addr);
                m_streak = 0;
                pi = 0; i_req = 0;
            end
            chk($sformatf("rnd%0d_rdata", n), rdata, m_rdata);
            ar_wait = $urandom_range(3); r_wait = $urandom_range(3); aw_wait = $urandom_range(3);
            w_wait = $urandom_range(3); b_wait = $urandom_range(3);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
